m68k_bus_responder: RTL and testbench

- 68000 bus target: answers asynchronous 68k bus cycles (AS_n/UDS_n/LDS_n/RW) that hit one address window. Ends each cycle with DTACK_n, or with BERR_n on timeout.
- Sits on the 68k side, opposite the PiStorm bus initiator. Used for loopback bring-up and for Pi-visible mailbox/register space emulation.
- Oversamples the bus on the fast PI_CLK domain. Forwards each hit to a local register/memory store over a req/ack handshake.

---
 rtl/pistorm_pkg.sv | 13 +
 rtl/bus_sync.sv | 21 ++
 rtl/m68k_bus_responder.sv | 98 +++++++++
 tb/tb_m68k_bus_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pistorm_pkg.sv
// pistorm_pkg: shared state, byte-lane and address-window definitions for PiStorm fast-clock blocks
package pistorm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_REQ, S_ACK, S_BERR, S_IGNORE, S_DRAIN} state_t;
  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_WORD  = 2'b11;
  localparam logic [23:0] DEF_BASE_ADDR = 24'hE80000;
  localparam logic [23:0] DEF_ADDR_MASK = 24'hFF0000;
  function automatic logic addr_hit(input logic [23:0] a, input logic [23:0] base, input logic [23:0] mask);
    return ((a ^ base) & mask) == 24'd0;
  endfunction
endpackage

// File: rtl/bus_sync.sv
// bus_sync: N-bit two-flop synchroniser with a configurable reset value
module bus_sync #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // two flops in series to settle metastability from the asynchronous bus
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: 68000 bus target forwarding window hits to a local store, ending with DTACK or BERR
module m68k_bus_responder import pistorm_pkg::*; #(
  parameter logic [23:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [23:0] ADDR_MASK   = DEF_ADDR_MASK,
  parameter int          TIMEOUT_CYC = 255,
  parameter int          MIN_WAIT    = 2
) (
  input  logic        PI_CLK,
  input  logic        M68K_RESET_n,
  input  logic [23:0] M68K_A,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);
  state_t      state, state_d;
  logic        as_s, uds_s, lds_s, rw_s;
  logic        armed, hit_q, start;
  logic [15:0] cnt;

  bus_sync #(.W(4), .RST_VAL(4'hF)) u_sync (
    .clk  (PI_CLK),
    .rst_n(M68K_RESET_n),
    .d    ({M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW}),
    .q    ({as_s, uds_s, lds_s, rw_s})
  );

  assign start = state == S_IDLE && armed && !as_s && !(uds_s && lds_s);
  assign busy  = state != S_IDLE;

  // next-state: abort beats ack, ack beats timeout, misses never touch DTACK/BERR
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   state_d = start ? S_DECODE : S_IDLE;
      S_DECODE: state_d = hit_q ? S_REQ : S_IGNORE;
      S_REQ:    state_d = as_s ? (mem_ack ? S_IDLE : S_DRAIN) :
                          mem_ack ? S_ACK :
                          cnt >= 16'(TIMEOUT_CYC) ? S_BERR : S_REQ;
      S_ACK:    state_d = as_s ? S_IDLE : S_ACK;
      S_BERR:   state_d = as_s ? (mem_req && !mem_ack ? S_DRAIN : S_IDLE) : S_BERR;
      S_IGNORE: state_d = as_s ? S_IDLE : S_IGNORE;
      S_DRAIN:  state_d = mem_ack || !mem_req ? S_IDLE : S_DRAIN;
      default:  state_d = S_IDLE;
    endcase
  end

  // state, capture, store handshake and registered bus outputs; reset drops bus drivers at once
  always_ff @(posedge PI_CLK or negedge M68K_RESET_n)
    if (!M68K_RESET_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      armed        <= 1'b0;
      hit_q        <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= BE_NONE;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      M68K_D_OUT   <= '0;
      M68K_D_OE    <= 1'b0;
      M68K_DTACK_n <= 1'b1;
      M68K_BERR_n  <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= state == S_DECODE ? '0 : (&cnt ? cnt : cnt + 16'd1);
      armed <= as_s | (armed & ~start);
      if (start) begin
        hit_q     <= addr_hit(M68K_A, BASE_ADDR, ADDR_MASK);
        mem_addr  <= M68K_A[23:1];
        mem_wdata <= M68K_D_IN;
      end
      if (state == S_DECODE && hit_q) begin
        mem_req <= 1'b1;
        mem_we  <= ~rw_s;
        mem_be  <= {~uds_s, ~lds_s};
      end else if (mem_ack)
        mem_req <= 1'b0;
      if (state == S_REQ && state_d == S_ACK && !mem_we)
        M68K_D_OUT <= mem_rdata;
      M68K_D_OE    <= state == S_ACK && !as_s && !mem_we && ({1'b0, cnt} + 17'd1 >= 17'(MIN_WAIT));
      M68K_DTACK_n <= !(state == S_ACK && !as_s && cnt >= 16'(MIN_WAIT) && (mem_we || M68K_D_OE));
      M68K_BERR_n  <= state_d != S_BERR;
    end
endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder: directed bus cycles with a request/response scoreboard
module tb_m68k_bus_responder;
  import pistorm_pkg::*;

  logic        PI_CLK = 1'b0;
  logic        M68K_RESET_n;
  logic [23:0] M68K_A;
  logic [15:0] M68K_D_IN, M68K_D_OUT;
  logic        M68K_D_OE, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW;
  logic        M68K_DTACK_n, M68K_BERR_n;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [22:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;

  m68k_bus_responder #(.TIMEOUT_CYC(8)) dut (
    .PI_CLK(PI_CLK), .M68K_RESET_n(M68K_RESET_n), .M68K_A(M68K_A),
    .M68K_D_IN(M68K_D_IN), .M68K_D_OUT(M68K_D_OUT), .M68K_D_OE(M68K_D_OE),
    .M68K_AS_n(M68K_AS_n), .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n),
    .M68K_RW(M68K_RW), .M68K_DTACK_n(M68K_DTACK_n), .M68K_BERR_n(M68K_BERR_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 PI_CLK = ~PI_CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic we; logic [22:0] addr; logic [1:0] be; logic [15:0] wdata;} req_t;
  typedef struct {logic rd; logic [15:0] data;} rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];

  // store model
  logic        ack_hold = 1'b0;
  int          ack_dly  = 3;
  logic [15:0] rd_val   = 16'h0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge PI_CLK);
      if (mem_req && !mem_ack) begin
        repeat (ack_dly) @(negedge PI_CLK);
        while (ack_hold) @(negedge PI_CLK);
        mem_rdata = rd_val;
        mem_ack   = 1'b1;
        @(negedge PI_CLK);
        mem_ack   = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard on each new store request and each DTACK assertion
  initial begin
    logic prev_req, prev_dtack, prev_oe;
    req_t e;
    rsp_t r;
    prev_req = 1'b0; prev_dtack = 1'b1; prev_oe = 1'b0;
    forever begin
      @(negedge PI_CLK);
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
        end else begin
          e = req_q.pop_front();
          chk("req_we", 32'(mem_we), 32'(e.we));
          chk("req_addr", 32'(mem_addr), 32'(e.addr));
          chk("req_be", 32'(mem_be), 32'(e.be));
          if (e.we) chk("req_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end
      if (!M68K_DTACK_n && prev_dtack) begin
        if (rsp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_dtack: got DTACK_n 0 expected 1");
        end else begin
          r = rsp_q.pop_front();
          chk("dtack_oe", 32'(M68K_D_OE), 32'(r.rd));
          if (r.rd) begin
            chk("d_out", 32'(M68K_D_OUT), 32'(r.data));
            chk("oe_lead", 32'(prev_oe), 1);
          end
        end
      end
      prev_req = mem_req; prev_dtack = M68K_DTACK_n; prev_oe = M68K_D_OE;
    end
  end

  task automatic bus_start(input logic [23:0] a, input logic u, input logic l, input logic rw, input logic [15:0] d);
    @(negedge PI_CLK);
    M68K_A = a; M68K_D_IN = d; M68K_RW = rw;
    M68K_AS_n = 1'b0; M68K_UDS_n = u; M68K_LDS_n = l;
  endtask

  task automatic wait_term(input int bound, output logic dt, output logic be);
    dt = 1'b0; be = 1'b0;
    for (int i = 0; i < bound && !dt && !be; i++) begin
      @(negedge PI_CLK);
      dt = !M68K_DTACK_n;
      be = !M68K_BERR_n;
    end
  endtask

  task automatic bus_end(output int cyc);
    M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1; M68K_RW = 1'b1;
    cyc = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge PI_CLK);
      if (cyc == 99 && M68K_DTACK_n && M68K_BERR_n && !M68K_D_OE) cyc = i;
    end
  endtask

  task automatic wait_idle(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge PI_CLK);
      ok = !busy;
    end
  endtask

  task automatic wait_req(input int bound, output logic ok);
    ok = mem_req;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge PI_CLK);
      ok = mem_req;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dt, be, ok;
    int c, t;
    M68K_RESET_n = 1'b0; M68K_A = '0; M68K_D_IN = '0; M68K_RW = 1'b1;
    M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1;
    repeat (3) @(negedge PI_CLK);
    chk("rst_dtack", 32'(M68K_DTACK_n), 1);
    chk("rst_berr", 32'(M68K_BERR_n), 1);
    chk("rst_oe", 32'(M68K_D_OE), 0);
    chk("rst_dout", 32'(M68K_D_OUT), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_busy", 32'(busy), 0);
    M68K_RESET_n = 1'b1;
    repeat (3) @(negedge PI_CLK);

    // read hit, AS held low after DTACK to confirm no double fire
    ack_dly = 3; rd_val = 16'h1234;
    req_q.push_back('{1'b0, 23'h740008, BE_WORD, 16'h0});
    rsp_q.push_back('{1'b1, 16'h1234});
    bus_start(24'hE80010, 1'b0, 1'b0, 1'b1, 16'h0);
    wait_term(40, dt, be);
    chk("rd_dtack", 32'(dt), 1);
    chk("rd_berr", 32'(be), 0);
    repeat (6) @(negedge PI_CLK);
    chk("rd_held_no_refire", 32'(mem_req), 0);
    chk("rd_dtack_held", 32'(M68K_DTACK_n), 0);
    bus_end(c);
    chk("rd_release_le3", 32'(c <= 3), 1);

    // byte write on the lower lane
    ack_dly = 2;
    req_q.push_back('{1'b1, 23'h740010, BE_LOWER, 16'h00AB});
    rsp_q.push_back('{1'b0, 16'h0});
    bus_start(24'hE80021, 1'b1, 1'b0, 1'b0, 16'h00AB);
    wait_term(40, dt, be);
    chk("wr_dtack", 32'(dt), 1);
    chk("wr_oe", 32'(M68K_D_OE), 0);
    bus_end(c);
    chk("wr_release_le3", 32'(c <= 3), 1);

    // miss: nothing driven, no request
    bus_start(24'hBFE001, 1'b1, 1'b0, 1'b1, 16'h0);
    wait_term(20, dt, be);
    chk("miss_dtack", 32'(dt), 0);
    chk("miss_berr", 32'(be), 0);
    chk("miss_req", 32'(mem_req), 0);
    bus_end(c);
    wait_idle(5, ok);
    chk("miss_idle", 32'(ok), 1);

    // timeout: store stalls, BERR once the counter reaches 8, then drain on the late ack
    ack_hold = 1'b1; ack_dly = 0;
    req_q.push_back('{1'b0, 23'h740080, BE_WORD, 16'h0});
    bus_start(24'hE80100, 1'b0, 1'b0, 1'b1, 16'h0);
    wait_req(10, ok);
    chk("to_req", 32'(ok), 1);
    t = 0;
    while (M68K_BERR_n && t < 30) begin
      @(negedge PI_CLK);
      t++;
    end
    chk("to_berr_cycles", 32'(t), 9);
    chk("to_no_dtack", 32'(M68K_DTACK_n), 1);
    bus_end(c);
    chk("to_release_le3", 32'(c <= 3), 1);
    chk("to_drain_busy", 32'(busy), 1);
    chk("to_drain_req", 32'(mem_req), 1);
    ack_hold = 1'b0;
    wait_idle(10, ok);
    chk("to_idle_after_ack", 32'(ok), 1);

    // abort in REQ, then a normal hit
    ack_hold = 1'b1;
    req_q.push_back('{1'b0, 23'h740020, BE_WORD, 16'h0});
    bus_start(24'hE80040, 1'b0, 1'b0, 1'b1, 16'h0);
    wait_req(10, ok);
    chk("ab_req", 32'(ok), 1);
    bus_end(c);
    chk("ab_drain_busy", 32'(busy), 1);
    chk("ab_req_held", 32'(mem_req), 1);
    ack_hold = 1'b0;
    wait_idle(10, ok);
    chk("ab_idle", 32'(ok), 1);
    ack_dly = 1;
    req_q.push_back('{1'b1, 23'h740021, BE_WORD, 16'hBEEF});
    rsp_q.push_back('{1'b0, 16'h0});
    bus_start(24'hE80042, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    wait_term(40, dt, be);
    chk("ab_next_dtack", 32'(dt), 1);
    bus_end(c);
    chk("ab_next_release", 32'(c <= 3), 1);

    // reset while DTACK is asserted
    ack_dly = 0; rd_val = 16'h5A5A;
    req_q.push_back('{1'b0, 23'h740004, BE_WORD, 16'h0});
    rsp_q.push_back('{1'b1, 16'h5A5A});
    bus_start(24'hE80008, 1'b0, 1'b0, 1'b1, 16'h0);
    wait_term(40, dt, be);
    chk("rs_dtack", 32'(dt), 1);
    #2 M68K_RESET_n = 1'b0;
    #1;
    chk("rs_async_dtack", 32'(M68K_DTACK_n), 1);
    chk("rs_async_oe", 32'(M68K_D_OE), 0);
    chk("rs_async_busy", 32'(busy), 0);
    M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1;
    repeat (2) @(negedge PI_CLK);
    M68K_RESET_n = 1'b1;
    repeat (5) @(negedge PI_CLK);
    chk("rs_post_busy", 32'(busy), 0);
    chk("rs_post_dtack", 32'(M68K_DTACK_n), 1);

    repeat (5) @(negedge PI_CLK);
    chk("req_q_empty", 32'(req_q.size()), 0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
